// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and width helpers for the raster
// generator and its consumers.
package vga_pkg;

   localparam int H_ACTIVE_640 = 640;
   localparam int H_FP_640     = 16;
   localparam int H_SYNC_640   = 96;
   localparam int H_BP_640     = 48;
   localparam int V_ACTIVE_480 = 480;
   localparam int V_FP_480     = 10;
   localparam int V_SYNC_480   = 2;
   localparam int V_BP_480     = 33;
   localparam int CW_DEF       = 12;

   localparam int H_TOTAL_640 = H_SYNC_640 + H_BP_640 + H_ACTIVE_640 + H_FP_640;
   localparam int V_TOTAL_480 = V_SYNC_480 + V_BP_480 + V_ACTIVE_480 + V_FP_480;
   localparam int H_START_640 = H_SYNC_640 + H_BP_640;
   localparam int V_START_480 = V_SYNC_480 + V_BP_480;

   // Bits needed to hold 0..n-1.
   function automatic int width_for(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: pixel enable in, syncs/enable/coordinates/strobes out.
interface vga_timing_gen_if import vga_pkg::*; #(
   parameter int CW = CW_DEF
) ();

   logic          ce;
   logic          hsync;
   logic          vsync;
   logic          de;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          line_start;
   logic          frame_start;

   modport master (input ce, output hsync, vsync, de, x, y, line_start, frame_start);
   modport slave  (output ce, input hsync, vsync, de, x, y, line_start, frame_start);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter 0..TOTAL-1 with sync and active-window
// decode of the current count.
module vga_axis_counter import vga_pkg::*; #(
   parameter int CW        = CW_DEF,
   parameter int TOTAL     = H_TOTAL_640,
   parameter int SYNC      = H_SYNC_640,
   parameter int ACT_START = H_START_640,
   parameter int ACTIVE    = H_ACTIVE_640
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          count_en,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          sync_act,
   output logic          active
);

   localparam logic [CW-1:0] LAST_C  = CW'(TOTAL - 1);
   localparam logic [CW-1:0] SYNC_C  = CW'(SYNC);
   localparam logic [CW-1:0] START_C = CW'(ACT_START);
   // One extra bit: the window end may equal TOTAL, which can be 2**CW.
   localparam logic [CW:0]   END_C   = (CW+1)'(ACT_START + ACTIVE);

   assign wrap     = (count == LAST_C);
   assign sync_act = (count < SYNC_C);
   assign active   = (count >= START_C) && ({1'b0, count} < END_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           count <= '0;
      else if (count_en) count <= wrap ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: registered syncs, display enable,
// pixel coordinates and line/frame strobes, advancing one pixel per ce.
module vga_timing_gen import vga_pkg::*; #(
   parameter int H_ACTIVE = H_ACTIVE_640,
   parameter int H_FP     = H_FP_640,
   parameter int H_SYNC   = H_SYNC_640,
   parameter int H_BP     = H_BP_640,
   parameter int V_ACTIVE = V_ACTIVE_480,
   parameter int V_FP     = V_FP_480,
   parameter int V_SYNC   = V_SYNC_480,
   parameter int V_BP     = V_BP_480,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = CW_DEF
) (
   input  logic                clk,
   input  logic                rst,
   vga_timing_gen_if.master    vga
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_START = H_SYNC + H_BP;
   localparam int V_START = V_SYNC + V_BP;
   localparam logic [CW-1:0] H_START_C = CW'(H_START);
   localparam logic [CW-1:0] V_START_C = CW'(V_START);

   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
       width_for(H_TOTAL) > CW || width_for(V_TOTAL) > CW) begin : g_bad_cfg
      $fatal(1, "vga_timing_gen: zero timing parameter or CW too narrow");
   end

   logic [CW-1:0] h_count, v_count;
   logic          h_wrap, v_wrap_unused;
   logic          h_sync_act, v_sync_act, h_act, v_act;
   logic          de_nxt;

   vga_axis_counter #(
      .CW(CW), .TOTAL(H_TOTAL), .SYNC(H_SYNC), .ACT_START(H_START), .ACTIVE(H_ACTIVE)
   ) u_h (
      .clk(clk), .rst(rst), .count_en(vga.ce),
      .count(h_count), .wrap(h_wrap), .sync_act(h_sync_act), .active(h_act)
   );

   vga_axis_counter #(
      .CW(CW), .TOTAL(V_TOTAL), .SYNC(V_SYNC), .ACT_START(V_START), .ACTIVE(V_ACTIVE)
   ) u_v (
      .clk(clk), .rst(rst), .count_en(vga.ce & h_wrap),
      .count(v_count), .wrap(v_wrap_unused), .sync_act(v_sync_act), .active(v_act)
   );

   assign de_nxt = h_act & v_act;

   // Outputs decode the counter state seen on this ce, so they trail it by one ce.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga.hsync       <= ~HS_POL;
         vga.vsync       <= ~VS_POL;
         vga.de          <= 1'b0;
         vga.x           <= '0;
         vga.y           <= '0;
         vga.line_start  <= 1'b0;
         vga.frame_start <= 1'b0;
      end else if (vga.ce) begin
         vga.hsync       <= h_sync_act ? HS_POL : ~HS_POL;
         vga.vsync       <= v_sync_act ? VS_POL : ~VS_POL;
         vga.de          <= de_nxt;
         vga.x           <= de_nxt ? h_count - H_START_C : '0;
         vga.y           <= de_nxt ? v_count - V_START_C : '0;
         vga.line_start  <= (h_count == '0);
         vga.frame_start <= (h_count == '0) && (v_count == '0);
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Small-raster bench: outputs are predicted from the number of ce cycles
// taken since reset, under ce=1, random ce, stalls and mid-frame resets.
module tb_vga_timing_gen;

   localparam int HA = 4, HF = 2, HS = 3, HB = 1;
   localparam int VA = 2, VF = 1, VS = 2, VB = 1;
   localparam int HT = HS + HB + HA + HF;   // 10
   localparam int VT = VS + VB + VA + VF;   // 6
   localparam int FRAME = HT * VT;          // 60
   localparam int HSP = 1, VSP = 0;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ce_cnt = 0;
   int   phase = 0;
   bit   started = 1'b0;
   int   n_chk = 0, n_fail = 0;
   int   de_cnt = 0, hs_cnt = 0, vs_cnt = 0, ls_cnt = 0, fs_cnt = 0;

   vga_timing_gen_if #(.CW(CW)) vif ();

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b0), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .vga(vif)
   );

   always #5 clk = ~clk;

   // Number of ce cycles the raster has taken since the last reset.
   always @(posedge clk or posedge rst) begin
      if (rst)         ce_cnt <= 0;
      else if (vif.ce) ce_cnt <= ce_cnt + 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at ce_cnt=%0d phase=%0d: got %0d expected %0d", nm, ce_cnt, phase, act, exp);
      end
   endtask

   // After k ce cycles the outputs show raster position k-1 (mod one frame).
   task automatic model(input int k, output int e_hs, output int e_vs, output int e_de,
                        output int e_x, output int e_y, output int e_ls, output int e_fs);
      int p, h, v;
      if (k == 0) begin
         e_hs = 1 - HSP; e_vs = 1 - VSP;
         e_de = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0;
      end else begin
         p = (k - 1) % FRAME;
         h = p % HT;
         v = p / HT;
         e_hs = (h < HS) ? HSP : 1 - HSP;
         e_vs = (v < VS) ? VSP : 1 - VSP;
         e_de = (h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA) ? 1 : 0;
         e_x  = e_de ? h - (HS + HB) : 0;
         e_y  = e_de ? v - (VS + VB) : 0;
         e_ls = (h == 0) ? 1 : 0;
         e_fs = (p == 0) ? 1 : 0;
      end
   endtask

   always @(negedge clk) begin
      int e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs;
      if (started) begin
         model(ce_cnt, e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs);
         chk("hsync", int'(vif.hsync), e_hs);
         chk("vsync", int'(vif.vsync), e_vs);
         chk("de", int'(vif.de), e_de);
         chk("x", int'(vif.x), e_x);
         chk("y", int'(vif.y), e_y);
         chk("line_start", int'(vif.line_start), e_ls);
         chk("frame_start", int'(vif.frame_start), e_fs);

         // Hand-computed points for the 10x6 raster, ce held high.
         if (phase == 1) begin
            case (ce_cnt)
               1:  begin chk("k1_hsync", int'(vif.hsync), 1); chk("k1_vsync", int'(vif.vsync), 0);
                         chk("k1_frame_start", int'(vif.frame_start), 1); chk("k1_de", int'(vif.de), 0); end
               4:  chk("k4_hsync_off", int'(vif.hsync), 0);
               21: begin chk("k21_vsync_off", int'(vif.vsync), 1); chk("k21_line_start", int'(vif.line_start), 1); end
               35: begin chk("first_de", int'(vif.de), 1); chk("first_x", int'(vif.x), 0); chk("first_y", int'(vif.y), 0); end
               48: begin chk("last_de", int'(vif.de), 1); chk("last_x", int'(vif.x), 3); chk("last_y", int'(vif.y), 1); end
               49: chk("after_last_de", int'(vif.de), 0);
               61: begin
                  chk("frame2_start", int'(vif.frame_start), 1);
                  chk("de_per_frame", de_cnt, 8);
                  chk("hsync_act_per_frame", hs_cnt, 18);
                  chk("vsync_act_per_frame", vs_cnt, 20);
                  chk("lines_per_frame", ls_cnt, 6);
                  chk("frames_per_frame", fs_cnt, 1);
               end
               default: ;
            endcase
            if (ce_cnt >= 1 && ce_cnt <= FRAME) begin
               de_cnt += int'(vif.de);
               hs_cnt += int'(vif.hsync);
               vs_cnt += int'(!vif.vsync);
               ls_cnt += int'(vif.line_start);
               fs_cnt += int'(vif.frame_start);
            end
         end
         if (phase == 3 && ce_cnt == 1) begin
            chk("post_rst_frame_start", int'(vif.frame_start), 1);
            chk("post_rst_hsync", int'(vif.hsync), 1);
            chk("post_rst_vsync", int'(vif.vsync), 0);
            chk("post_rst_de", int'(vif.de), 0);
         end
      end
   end

   function automatic logic rnd_ce();
      return ($urandom_range(0, 99) < 30);
   endfunction

   task automatic step(input logic c);
      @(posedge clk);
      #2 vif.ce = c;
   endtask

   initial begin
      vif.ce = 1'b0;
      @(posedge clk);
      #2 started = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      phase = 1;
      vif.ce = 1'b1;
      repeat (3 * FRAME + 5) step(1'b1);

      phase = 2;
      repeat (700) step(rnd_ce());

      phase = 3;
      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(50, 150)) step(rnd_ce());
         @(posedge clk);
         #2 rst = 1'b1;
         repeat (2) step(rnd_ce());
         rst = 1'b0;
         vif.ce = 1'b1;
         repeat (3) step(1'b1);
         repeat (120) step(rnd_ce());
      end

      phase = 4;
      repeat (40) step(1'b0);
      repeat (150) step(1'b1);
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
